// File: rtl/sequenciador_faces.sv
// Cube-scan scheduler: captures N_FACES faces through the OV7670 capture interface,
// stepping the motor between faces. Optional watchdog enabled by SCAN_WATCHDOG_EN.
module sequenciador_faces #(
  parameter int N_FACES       = 6,
  parameter int SETTLE_CYCLES = 1000,
  parameter int WD_CYCLES     = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic       cam_pronto,
  input  logic       mov_ack,
  output logic       cam_iniciar,
  output logic       mov_req,
  output logic [2:0] mov_codigo,
  output logic [2:0] face_idx,
  output logic       face_valida,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  // Handshakes: cam_iniciar is a one-cycle pulse, cam_pronto is taken on any edge
  // where it is high in espera_camera; mov_req stays high until the edge that sees mov_ack.
  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    PREPARA       = 4'b0001,
    CAPTURA       = 4'b0010,
    ESPERA_CAMERA = 4'b0011,
    REGISTRA      = 4'b0100,
    MOVIMENTA     = 4'b0101,
    ESPERA_ESTAB  = 4'b0110,
    FIM           = 4'b0111,
    ERRO          = 4'b1001
  } estado_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] FACE_LAST = 3'(N_FACES - 1);

  if (N_FACES < 1 || N_FACES > 8 || SETTLE_CYCLES < 1 || WD_CYCLES < 1) begin : g_param_check
    $error("sequenciador_faces: parameter out of range");
  end

  estado_t       estado;
  logic [2:0]    face_q;
  logic [SW-1:0] settle_cnt;

`ifdef SCAN_WATCHDOG_EN
  localparam int WW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_expirou;

  assign wd_expirou = (wd_cnt == WD_LAST);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      face_q     <= '0;
      settle_cnt <= '0;
`ifdef SCAN_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
`ifdef SCAN_WATCHDOG_EN
      // Cleared on every cycle except while still waiting on a handshake.
      wd_cnt <= '0;
`endif
      if (abortar) begin
        estado     <= INICIAL;
        face_q     <= '0;
        settle_cnt <= '0;
      end else begin
        case (estado)
          INICIAL: if (iniciar) estado <= PREPARA;
          PREPARA: begin
            face_q     <= '0;
            settle_cnt <= '0;
            estado     <= CAPTURA;
          end
          CAPTURA: estado <= ESPERA_CAMERA;
          ESPERA_CAMERA: begin
            if (cam_pronto) estado <= REGISTRA;
`ifdef SCAN_WATCHDOG_EN
            else if (wd_expirou) estado <= ERRO;
            else wd_cnt <= wd_cnt + 1'b1;
`endif
          end
          REGISTRA: estado <= (face_q == FACE_LAST) ? FIM : MOVIMENTA;
          MOVIMENTA: begin
            if (mov_ack) begin
              face_q <= face_q + 3'd1;
              estado <= ESPERA_ESTAB;
            end
`ifdef SCAN_WATCHDOG_EN
            else if (wd_expirou) estado <= ERRO;
            else wd_cnt <= wd_cnt + 1'b1;
`endif
          end
          ESPERA_ESTAB: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              estado     <= CAPTURA;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          FIM:  estado <= INICIAL;
          ERRO: if (iniciar) estado <= PREPARA;
          default: estado <= INICIAL;
        endcase
      end
    end
  end

  // Moore outputs, decoded straight from the state register.
  assign cam_iniciar = (estado == CAPTURA);
  assign mov_req     = (estado == MOVIMENTA);
  assign mov_codigo  = mov_req ? (face_q + 3'd1) : 3'd0;
  assign face_idx    = face_q;
  assign face_valida = (estado == REGISTRA);
  assign pronto      = (estado == FIM);
  assign db_estado   = estado;
`ifdef SCAN_WATCHDOG_EN
  assign erro        = (estado == ERRO);
`else
  assign erro        = 1'b0;
`endif

endmodule
